// File: rtl/ex_wb_backend_if.sv
// rtl/ex_wb_backend_if.sv - ID/EX pipeline register bundle feeding the EX/WB backend
interface ex_wb_backend_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
);
  logic              ID_EX_RegWrite;
  logic              ID_EX_ALUSrc;
  logic [DATA_W-1:0] ID_EX_Read_Data;
  logic [DATA_W-1:0] ID_EX_Imm_Data;
  logic [REG_AW-1:0] ID_EX_Read_Reg_Num;
  logic [REG_AW-1:0] ID_EX_Write_Reg_Num;

  modport master (
    output ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_Read_Data,
           ID_EX_Imm_Data, ID_EX_Read_Reg_Num, ID_EX_Write_Reg_Num
  );

  modport slave (
    input ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_Read_Data,
          ID_EX_Imm_Data, ID_EX_Read_Reg_Num, ID_EX_Write_Reg_Num
  );
endinterface

// File: rtl/ex_wb_backend.sv
// rtl/ex_wb_backend.sv - EX/WB backend: forwarding, result select, EX/WB register, regfile
module ex_wb_backend #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  ex_wb_backend_if.slave    id_ex,
  input  logic [REG_AW-1:0] ID_Read_Reg_Num,
  output logic [DATA_W-1:0] ID_Read_Data,
  output logic              EX_WB_RegWrite,
  output logic [REG_AW-1:0] EX_WB_Write_Reg_Num,
  output logic [DATA_W-1:0] EX_WB_Result,
  output logic              Fwd_Active,
  output logic [CNT_W-1:0]  Retire_Count,
  input  logic [REG_AW-1:0] Dbg_Reg_Sel,
  output logic [DATA_W-1:0] Dbg_Reg_Data
);
  localparam int NREG = 1 << REG_AW;

  logic              ex_wb_reg_write_q, ex_wb_reg_write_d;
  logic [REG_AW-1:0] ex_wb_write_reg_num_q, ex_wb_write_reg_num_d;
  logic [DATA_W-1:0] ex_wb_result_q, ex_wb_result_d;
  logic [CNT_W-1:0]  retire_count_q, retire_count_d;
  logic [DATA_W-1:0] regfile_q [NREG];
  logic [DATA_W-1:0] regfile_d [NREG];

  logic              fwd_active;
  logic [DATA_W-1:0] operand;

  always_comb begin
    // Forwarding ignores ALUSrc on purpose: the flag reports the hazard, not its use.
    fwd_active = ex_wb_reg_write_q && (ex_wb_write_reg_num_q == id_ex.ID_EX_Read_Reg_Num);
    operand    = fwd_active ? ex_wb_result_q : id_ex.ID_EX_Read_Data;

    ex_wb_reg_write_d     = id_ex.ID_EX_RegWrite;
    ex_wb_write_reg_num_d = id_ex.ID_EX_Write_Reg_Num;
    ex_wb_result_d        = id_ex.ID_EX_ALUSrc ? id_ex.ID_EX_Imm_Data : operand;

    regfile_d      = regfile_q;
    retire_count_d = retire_count_q;
    if (ex_wb_reg_write_q) begin
      regfile_d[ex_wb_write_reg_num_q] = ex_wb_result_q;
      retire_count_d                   = retire_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ex_wb_reg_write_q     <= 1'b0;
      ex_wb_write_reg_num_q <= '0;
      ex_wb_result_q        <= '0;
      retire_count_q        <= '0;
      for (int i = 0; i < NREG; i++) begin
        regfile_q[i] <= '0;
      end
    end else begin
      ex_wb_reg_write_q     <= ex_wb_reg_write_d;
      ex_wb_write_reg_num_q <= ex_wb_write_reg_num_d;
      ex_wb_result_q        <= ex_wb_result_d;
      retire_count_q        <= retire_count_d;
      regfile_q             <= regfile_d;
    end
  end

  // Write-through bypass closes the WB-to-ID hazard without regfile read-during-write ordering.
  assign ID_Read_Data = (ex_wb_reg_write_q && (ex_wb_write_reg_num_q == ID_Read_Reg_Num))
                        ? ex_wb_result_q : regfile_q[ID_Read_Reg_Num];

  assign Dbg_Reg_Data        = regfile_q[Dbg_Reg_Sel];
  assign EX_WB_RegWrite      = ex_wb_reg_write_q;
  assign EX_WB_Write_Reg_Num = ex_wb_write_reg_num_q;
  assign EX_WB_Result        = ex_wb_result_q;
  assign Fwd_Active          = fwd_active;
  assign Retire_Count        = retire_count_q;
endmodule

// File: tb/tb_ex_wb_backend.sv
// tb/tb_ex_wb_backend.sv - table-driven directed bench for ex_wb_backend
module tb_ex_wb_backend;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [2:0]  ID_Read_Reg_Num;
  logic [7:0]  ID_Read_Data;
  logic        EX_WB_RegWrite;
  logic [2:0]  EX_WB_Write_Reg_Num;
  logic [7:0]  EX_WB_Result;
  logic        Fwd_Active;
  logic [15:0] Retire_Count;
  logic [2:0]  Dbg_Reg_Sel;
  logic [7:0]  Dbg_Reg_Data;

  int errors = 0;
  int checks = 0;

  ex_wb_backend_if #(.DATA_W(8), .REG_AW(3)) id_ex_if ();

  ex_wb_backend #(.DATA_W(8), .REG_AW(3), .CNT_W(16)) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .id_ex               (id_ex_if),
    .ID_Read_Reg_Num     (ID_Read_Reg_Num),
    .ID_Read_Data        (ID_Read_Data),
    .EX_WB_RegWrite      (EX_WB_RegWrite),
    .EX_WB_Write_Reg_Num (EX_WB_Write_Reg_Num),
    .EX_WB_Result        (EX_WB_Result),
    .Fwd_Active          (Fwd_Active),
    .Retire_Count        (Retire_Count),
    .Dbg_Reg_Sel         (Dbg_Reg_Sel),
    .Dbg_Reg_Data        (Dbg_Reg_Data)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rw;
    logic        src;
    logic [7:0]  rd;
    logic [7:0]  imm;
    logic [2:0]  rr;
    logic [2:0]  wr;
    logic [2:0]  idr;
    logic        exp_fwd;
    logic [7:0]  exp_idrd;
    logic [7:0]  exp_dbg;
    logic [7:0]  exp_res;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic src, input logic [7:0] rd, input logic [7:0] imm,
                       input logic [2:0] rr, input logic [2:0] wr);
    id_ex_if.ID_EX_RegWrite      = rw;
    id_ex_if.ID_EX_ALUSrc        = src;
    id_ex_if.ID_EX_Read_Data     = rd;
    id_ex_if.ID_EX_Imm_Data      = imm;
    id_ex_if.ID_EX_Read_Reg_Num  = rr;
    id_ex_if.ID_EX_Write_Reg_Num = wr;
  endtask

  task automatic check_regfile(input string tag, input logic [7:0] exp [8]);
    for (int r = 0; r < 8; r++) begin
      Dbg_Reg_Sel = 3'(r);
      #1;
      check($sformatf("%s_dbg_r%0d", tag, r), {24'd0, Dbg_Reg_Data}, {24'd0, exp[r]});
    end
  endtask

  initial begin
    logic [7:0] final_regs [8];
    logic [7:0] zero_regs [8];

    //            rw    src   rd     imm    rr    wr    idr   fwd   idrd   dbg    res    cnt
    vecs[0] = '{1'b1, 1'b1, 8'h00, 8'h5A, 3'd0, 3'd2, 3'd2, 1'b0, 8'h00, 8'h00, 8'h5A, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 8'h00, 8'h3C, 3'd2, 3'd1, 3'd2, 1'b1, 8'h5A, 8'h00, 8'h3C, 16'd1};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 8'h00, 3'd1, 3'd4, 3'd1, 1'b1, 8'h3C, 8'h00, 8'h3C, 16'd2};
    vecs[3] = '{1'b1, 1'b0, 8'h5A, 8'h00, 3'd2, 3'd5, 3'd2, 1'b0, 8'h5A, 8'h5A, 8'h5A, 16'd3};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hFF, 3'd0, 3'd6, 3'd4, 1'b0, 8'h3C, 8'h3C, 8'hFF, 16'd4};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 3'd6, 3'd7, 3'd6, 1'b0, 8'h00, 8'h00, 8'h00, 16'd4};
    vecs[6] = '{1'b1, 1'b1, 8'h00, 8'hA7, 3'd7, 3'd5, 3'd5, 1'b1, 8'h5A, 8'h5A, 8'hA7, 16'd5};
    vecs[7] = '{1'b1, 1'b1, 8'h00, 8'h11, 3'd5, 3'd5, 3'd5, 1'b1, 8'hA7, 8'h5A, 8'h11, 16'd6};
    vecs[8] = '{1'b1, 1'b0, 8'hA7, 8'h00, 3'd5, 3'd0, 3'd5, 1'b1, 8'h11, 8'hA7, 8'h11, 16'd7};
    vecs[9] = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0, 1'b1, 8'h11, 8'h00, 8'h00, 16'd8};

    final_regs = '{8'h11, 8'h3C, 8'h5A, 8'h00, 8'h3C, 8'h11, 8'h00, 8'h00};
    zero_regs  = '{default: 8'h00};

    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
    ID_Read_Reg_Num = 3'd0;
    Dbg_Reg_Sel     = 3'd0;
    Reset           = 1'b1;
    #12;
    check("rst_regwrite", {31'd0, EX_WB_RegWrite}, 32'd0);
    check("rst_result", {24'd0, EX_WB_Result}, 32'd0);
    check("rst_count", {16'd0, Retire_Count}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      drive(vecs[i].rw, vecs[i].src, vecs[i].rd, vecs[i].imm, vecs[i].rr, vecs[i].wr);
      ID_Read_Reg_Num = vecs[i].idr;
      Dbg_Reg_Sel     = vecs[i].idr;
      #1;
      check($sformatf("v%0d_fwd", i), {31'd0, Fwd_Active}, {31'd0, vecs[i].exp_fwd});
      check($sformatf("v%0d_idrd", i), {24'd0, ID_Read_Data}, {24'd0, vecs[i].exp_idrd});
      check($sformatf("v%0d_dbg", i), {24'd0, Dbg_Reg_Data}, {24'd0, vecs[i].exp_dbg});
      @(posedge Clk);
      #1;
      check($sformatf("v%0d_res", i), {24'd0, EX_WB_Result}, {24'd0, vecs[i].exp_res});
      check($sformatf("v%0d_wb_rw", i), {31'd0, EX_WB_RegWrite}, {31'd0, vecs[i].rw});
      check($sformatf("v%0d_wb_wr", i), {29'd0, EX_WB_Write_Reg_Num}, {29'd0, vecs[i].wr});
      check($sformatf("v%0d_cnt", i), {16'd0, Retire_Count}, {16'd0, vecs[i].exp_cnt});
    end
    check_regfile("final", final_regs);

    // Reset mid-stream with a write in flight in EX/WB
    @(negedge Clk);
    drive(1'b1, 1'b1, 8'h00, 8'h99, 3'd0, 3'd3);
    @(posedge Clk);
    #2;
    ID_Read_Reg_Num = 3'd3;
    Reset = 1'b1;
    #1;
    check("midrst_regwrite", {31'd0, EX_WB_RegWrite}, 32'd0);
    check("midrst_wr", {29'd0, EX_WB_Write_Reg_Num}, 32'd0);
    check("midrst_result", {24'd0, EX_WB_Result}, 32'd0);
    check("midrst_idrd", {24'd0, ID_Read_Data}, 32'd0);
    check("midrst_count", {16'd0, Retire_Count}, 32'd0);
    check_regfile("midrst", zero_regs);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("postrst_count", {16'd0, Retire_Count}, 32'd0);
    check_regfile("postrst", zero_regs);

    // Counter wrap: continuous writes, count lags by one edge
    @(negedge Clk);
    drive(1'b1, 1'b1, 8'h00, 8'h42, 3'd0, 3'd3);
    for (int k = 0; k < 65536; k++) @(posedge Clk);
    #1;
    check("wrap_ffff", {16'd0, Retire_Count}, 32'h0000FFFF);
    @(posedge Clk);
    #1;
    check("wrap_zero", {16'd0, Retire_Count}, 32'h00000000);
    drive(1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 3'd0);
    Dbg_Reg_Sel = 3'd3;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("wrap_r3", {24'd0, Dbg_Reg_Data}, 32'h42);
    check("wrap_hold", {16'd0, Retire_Count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_wb_backend.md
Name: ex_wb_backend

Overview:
- Consumer end of the ID/EX pipeline register in the 8-bit pipelined core.
- Takes the registered ID/EX control and data, applies EX/WB-to-EX forwarding, and selects the result (register move or load immediate).
- Registers the result into the EX/WB stage and writes it into the 8-entry register file.
- Serves the ID stage's register read port, with write-through bypass, so the loop back into ID/EX closes here.

Parameters:
- DATA_W, 8, datapath and register width
- REG_AW, 3, register-number width; the register file has 2^REG_AW entries
- CNT_W, 16, width of the retired-write counter

Ports:
- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- ID_EX_RegWrite  input  1  instruction in EX writes a register
- ID_EX_ALUSrc  input  1  1 = result is immediate; 0 = result is source register
- ID_EX_Read_Data  input  DATA_W  source register value captured in ID
- ID_EX_Imm_Data  input  DATA_W  immediate value
- ID_EX_Read_Reg_Num  input  REG_AW  source register number
- ID_EX_Write_Reg_Num  input  REG_AW  destination register number
- ID_Read_Reg_Num  input  REG_AW  register number requested by the ID stage
- ID_Read_Data  output  DATA_W  register value for the ID stage (combinational)
- EX_WB_RegWrite  output  1  registered write enable of the WB stage
- EX_WB_Write_Reg_Num  output  REG_AW  registered destination of the WB stage
- EX_WB_Result  output  DATA_W  registered result of the WB stage
- Fwd_Active  output  1  combinational; forwarding selected this cycle
- Retire_Count  output  CNT_W  number of completed register writes
- Dbg_Reg_Sel  input  REG_AW  debug register select
- Dbg_Reg_Data  output  DATA_W  raw register-file contents at Dbg_Reg_Sel (combinational, no bypass)

Behaviour:
- Reset is asynchronous, active-high; clock is Clk. While Reset = 1:
  - EX_WB_RegWrite = 0, EX_WB_Write_Reg_Num = 0, EX_WB_Result = 0.
  - All register-file entries = 0; Retire_Count = 0.
- Forwarding (EX stage, combinational):
  - Fwd_Active = EX_WB_RegWrite && (EX_WB_Write_Reg_Num == ID_EX_Read_Reg_Num).
  - Operand = Fwd_Active ? EX_WB_Result : ID_EX_Read_Data.
  - Forwarding is never qualified by ID_EX_ALUSrc; Fwd_Active may assert even when the immediate is selected.
- Result = ID_EX_ALUSrc ? ID_EX_Imm_Data : Operand. The result is exactly DATA_W bits; no arithmetic and no width change.
- EX/WB register:
  - On every rising edge, EX_WB_RegWrite <= ID_EX_RegWrite, EX_WB_Write_Reg_Num <= ID_EX_Write_Reg_Num, EX_WB_Result <= Result.
  - Latency is one cycle from ID/EX to EX/WB. There is no stall and no flush; the upstream inserts a bubble by driving RegWrite = 0.
- Write-back:
  - On a rising edge with EX_WB_RegWrite = 1, regfile[EX_WB_Write_Reg_Num] <= EX_WB_Result, and Retire_Count increments by 1.
  - Retire_Count wraps from 2^CNT_W-1 to 0.
  - An instruction's register-file write lands two edges after it is presented at the ID/EX inputs.
  - All 2^REG_AW registers are writable; no register is hardwired to zero.
- ID read port:
  - ID_Read_Data = (EX_WB_RegWrite && EX_WB_Write_Reg_Num == ID_Read_Reg_Num) ? EX_WB_Result : regfile[ID_Read_Reg_Num].
  - This write-through bypass removes the WB-to-ID hazard.
- Back-to-back writes to the same register: each edge writes the newest EX/WB value, and forwarding always uses the youngest (EX/WB) value.
- Reset mid-operation: in-flight EX/WB contents are discarded, with no write. Registers read 0 immediately after Reset asserts.
- The same-edge write and read of one register are resolved only by the bypass paths; the register file itself has no read-during-write ordering requirement.

Test Plan:
- Reset asserted mid-stream, ID_Read_Reg_Num = 3 -> during Reset, all EX_WB outputs, ID_Read_Data, Dbg_Reg_Data for regs 0..7 and Retire_Count read 0; asynchronous assert with no clock edge needed.
- Load immediate: RegWrite = 1, ALUSrc = 1, Imm = 8'h5A, Write_Reg = 2 -> after edge 1, EX_WB_Result = 8'h5A and EX_WB_Write_Reg_Num = 2; after edge 2, Dbg_Reg_Data[2] = 8'h5A and Retire_Count = 1.
- Forwarding: edge 1 presents MVI r1,8'h3C; next cycle present MOV r4,r1 with ID_EX_Read_Data = 8'h00 (stale), ALUSrc = 0 -> Fwd_Active = 1 during that cycle; regfile[4] = 8'h3C two edges later.
- ID bypass: EX_WB holds write r5 = 8'hA7 and ID_Read_Reg_Num = 5 -> ID_Read_Data = 8'hA7 in the same cycle, while Dbg_Reg_Data[5] still shows the old value.
- Bubble: RegWrite = 0 with Write_Reg = 6 and Imm = 8'hFF -> regfile[6] unchanged, Retire_Count unchanged, Fwd_Active = 0 on the following instruction reading r6.
- Counter wrap: preload via 65535 writes -> Retire_Count = 16'hFFFF; one more write -> 16'h0000.
